// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: groups the button, counter and display signals of the
// stopwatch controller so they can be passed around as one bundle.
//
// Signals:
//   iStartStop, iClear, iLap  raw push-buttons (active-high, asynchronous)
//   iCount[15:0]              live BCD count from the counter chain
//   oCntEn                    count enable for the units counter
//   oCntClr                   one-cycle clear pulse to all counters
//   oDisp[15:0]               BCD value shown on the decoders
//   oState[1:0]               FSM state (00 IDLE, 01 RUN, 10 PAUSE, 11 LAP)
//
// Modports:
//   master  board/testbench side: drives buttons and count, reads outputs
//   slave   controller side
//
// Handshake: there is no valid/ready pair on this bundle. Buttons are plain
// levels, iCount is sampled whenever a lap is taken, and every output is
// meaningful on every cycle after reset.
interface stopwatch_ctrl_if;
  logic        iStartStop;
  logic        iClear;
  logic        iLap;
  logic [15:0] iCount;
  logic        oCntEn;
  logic        oCntClr;
  logic [15:0] oDisp;
  logic [1:0]  oState;

  modport master (
    output iStartStop, iClear, iLap, iCount,
    input  oCntEn, oCntClr, oDisp, oState
  );

  modport slave (
    input  iStartStop, iClear, iLap, iCount,
    output oCntEn, oCntClr, oDisp, oState
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear/lap controller for a 4-digit BCD counter
// chain. Each button is synchronised, debounced and edge-detected into a
// one-cycle event; a 4-state FSM turns events into count enable, counter
// clear and display selection.
//
// Parameters:
//   DEB_CYCLES  consecutive stable cycles needed to accept a level change
//
// Ports:
//   iClk        system clock, rising edge
//   iRst        synchronous active-high reset
//   bus         stopwatch_ctrl_if.slave (buttons, iCount, oCntEn, oCntClr,
//               oDisp, oState)
//
// Build option:
//   STOPWATCH_LAP_EN  when defined, the lap button front end and lap register
//                     are built and the LAP state becomes reachable. When not
//                     defined, iLap is ignored and oDisp always shows iCount.
module stopwatch_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic             iClk,
  input  logic             iRst,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // Button index: 0 start/stop, 1 clear, 2 lap (lap only when enabled).
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  localparam logic [15:0] DEB_LAST = DEB_CYCLES - 16'd1;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_deb;
  logic [NB-1:0] r_ev;
  logic [15:0]   r_deb_cnt [NB];

  logic          w_ev_ss;
  logic          w_ev_clr;
  logic          w_ev_lap;

  state_t        r_state;
  logic          r_cnt_en;
  logic          r_cnt_clr;

`ifdef STOPWATCH_LAP_EN
  logic [15:0]   r_lap;
  assign w_raw    = {bus.iLap, bus.iClear, bus.iStartStop};
  assign w_ev_lap = r_ev[2];
`else
  assign w_raw    = {bus.iClear, bus.iStartStop};
  assign w_ev_lap = 1'b0;
`endif

  assign w_ev_ss  = r_ev[0];
  assign w_ev_clr = r_ev[1];

  // Button front ends. The counter runs only while the synchronised level
  // disagrees with the accepted level; any agreement restarts it, so a level
  // must differ for DEB_CYCLES consecutive edges before it is accepted.
  // r_ev is raised on the same edge the accepted level rises.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_ev    <= '0;
      for (int i = 0; i < NB; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_ev    <= '0;
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
          r_ev[i]      <= r_sync2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Control FSM. Start/stop wins over clear, clear over lap; an event that
  // loses or is ignored in the current state is simply dropped.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap     <= 16'h0000;
`endif
    end else begin
      r_cnt_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ev_ss) begin
            r_state  <= S_RUN;
            r_cnt_en <= 1'b1;
          end else if (w_ev_clr) begin
            r_cnt_clr <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_ev_ss) begin
            r_state  <= S_PAUSE;
            r_cnt_en <= 1'b0;
`ifdef STOPWATCH_LAP_EN
          end else if (w_ev_lap) begin
            r_state <= S_LAP;
            r_lap   <= bus.iCount;
`endif
          end
        end
        S_PAUSE: begin
          if (w_ev_ss) begin
            r_state  <= S_RUN;
            r_cnt_en <= 1'b1;
          end else if (w_ev_clr) begin
            r_state   <= S_IDLE;
            r_cnt_clr <= 1'b1;
          end
        end
        S_LAP: begin
          // The counter keeps running here; only the display is frozen.
          if (w_ev_ss) begin
            r_state  <= S_PAUSE;
            r_cnt_en <= 1'b0;
          end else if (w_ev_lap) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oState  = r_state;
  assign bus.oCntEn  = r_cnt_en;
  assign bus.oCntClr = r_cnt_clr;

`ifdef STOPWATCH_LAP_EN
  assign bus.oDisp = (r_state == S_LAP) ? r_lap : bus.iCount;
`else
  assign bus.oDisp = bus.iCount;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: self-checking bench for stopwatch_ctrl with a debounce
// length of 4. A behavioural model derives the debounced events from a
// sliding window over the button history and applies the state table; one
// process compares every output on every falling clock edge. Directed
// sequences add hand-computed literal checks, then randomized button
// presses, BCD counts and resets run against the model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_LAP   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DEB_CYCLES(16'(DEB))) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int clr_hits;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int v);
    bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- behavioural model ----------------
  // A button's accepted level flips once the synchronised level (the raw
  // level two edges late) has disagreed with it for DEB straight edges,
  // i.e. the last DEB delayed samples all equal the opposite level.
  logic [DEB+1:0] hist [3];
  logic [2:0]     m_deb;
  logic [2:0]     m_pend;
  int             m_state;
  logic [15:0]    m_lap;
  logic           m_clr;
  bit             model_ok = 1'b0;

  always @(posedge clk) begin
    logic [2:0]     raw;
    logic [DEB-1:0] win;
    logic           ev_ss, ev_clr, ev_lap;
    if (rst) begin
      for (int b = 0; b < 3; b++) hist[b] = '0;
      m_deb    = '0;
      m_pend   = '0;
      m_state  = ST_IDLE;
      m_lap    = 16'h0000;
      m_clr    = 1'b0;
      model_ok = 1'b1;
    end else begin
      ev_ss  = m_pend[0];
      ev_clr = m_pend[1];
      ev_lap = m_pend[2] & LAP_EN;
      m_clr  = 1'b0;
      case (m_state)
        ST_IDLE:  if (ev_ss) m_state = ST_RUN;
                  else if (ev_clr) m_clr = 1'b1;
        ST_RUN:   if (ev_ss) m_state = ST_PAUSE;
                  else if (ev_lap) begin m_state = ST_LAP; m_lap = bus.iCount; end
        ST_PAUSE: if (ev_ss) m_state = ST_RUN;
                  else if (ev_clr) begin m_state = ST_IDLE; m_clr = 1'b1; end
        default:  if (ev_ss) m_state = ST_PAUSE;
                  else if (ev_lap) m_state = ST_RUN;
      endcase
      raw = {bus.iLap, bus.iClear, bus.iStartStop};
      for (int b = 0; b < 3; b++) begin
        hist[b]   = {hist[b][DEB:0], raw[b]};
        win       = hist[b][DEB+1:2];
        m_pend[b] = 1'b0;
        if (win == {DEB{~m_deb[b]}}) begin
          m_deb[b]  = ~m_deb[b];
          m_pend[b] = m_deb[b];
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      check("state", 16'(bus.oState), 16'(m_state));
      check("cnt_en", 16'(bus.oCntEn), 16'((m_state == ST_RUN) || (m_state == ST_LAP)));
      check("cnt_clr", 16'(bus.oCntClr), 16'(m_clr));
      check("disp", bus.oDisp, (m_state == ST_LAP) ? m_lap : bus.iCount);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [2:0] m);
    bus.iStartStop = m[0];
    bus.iClear     = m[1];
    bus.iLap       = m[2];
  endtask

  // Hold the masked buttons for 'hold' cycles, release, idle; counts the
  // cycles on which oCntClr was seen high over the whole window.
  task automatic press(input logic [2:0] m, input int hold, input int idle);
    clr_hits = 0;
    tick();
    set_btns(m);
    for (int i = 0; i < hold + idle; i++) begin
      tick();
      if (i == hold - 1) set_btns(3'b000);
      @(negedge clk);
      clr_hits += int'(bus.oCntClr);
    end
  endtask

  task automatic tick_rand();
    tick();
    bus.iCount = bcd($urandom_range(0, 9999));
    rst = ($urandom_range(0, 59) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  lap_state;
    logic [2:0]  mask;
    int          hold, gap;
    lap_state = LAP_EN ? 2'b11 : 2'b01;
    set_btns(3'b000);
    bus.iCount = 16'h0042;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 16'(bus.oState), 16'h0000);
    check("rst_en", 16'(bus.oCntEn), 16'h0000);
    check("rst_clr", 16'(bus.oCntClr), 16'h0000);
    check("rst_disp", bus.oDisp, 16'h0042);

    // Start: state must change on the 7th edge after the press.
    tick();
    bus.iStartStop = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("start_edge6", 16'(bus.oState), 16'h0000);
    @(negedge clk);
    check("start_edge7", 16'(bus.oState), 16'h0001);
    check("start_en", 16'(bus.oCntEn), 16'h0001);
    repeat (3) tick();
    bus.iStartStop = 1'b0;
    repeat (10) tick();

    // Lap freeze and release.
    bus.iCount = 16'h0123;
    press(3'b100, 8, 10);
    check("lap_state", 16'(bus.oState), 16'(lap_state));
    check("lap_disp", bus.oDisp, 16'h0123);
    for (int v = 124; v <= 130; v++) begin
      tick();
      bus.iCount = bcd(v);
      @(negedge clk);
      check("lap_hold_disp", bus.oDisp, LAP_EN ? 16'h0123 : bcd(v));
      check("lap_hold_en", 16'(bus.oCntEn), 16'h0001);
    end
    press(3'b100, 8, 10);
    check("lap_release_state", 16'(bus.oState), 16'h0001);
    check("lap_release_disp", bus.oDisp, 16'h0130);

    // Clear ignored in RUN, then pause and clear.
    press(3'b010, 8, 10);
    check("clr_in_run_pulses", 16'(clr_hits), 16'h0000);
    check("clr_in_run_state", 16'(bus.oState), 16'h0001);
    press(3'b001, 8, 10);
    check("pause_state", 16'(bus.oState), 16'h0002);
    check("pause_en", 16'(bus.oCntEn), 16'h0000);
    press(3'b010, 8, 10);
    check("clr_pulses", 16'(clr_hits), 16'h0001);
    check("clr_state", 16'(bus.oState), 16'h0000);

    // Glitches: 3-cycle pulses with 1-cycle gaps never debounce.
    for (int k = 0; k < 10; k++) begin
      bus.iStartStop = 1'b1;
      repeat (3) tick();
      bus.iStartStop = 1'b0;
      tick();
    end
    repeat (8) tick();
    @(negedge clk);
    check("glitch_state", 16'(bus.oState), 16'h0000);

    // Start/stop and clear accepted together in PAUSE: start/stop wins.
    press(3'b001, 8, 10);
    press(3'b001, 8, 10);
    check("pause2_state", 16'(bus.oState), 16'h0002);
    press(3'b011, 8, 10);
    check("ss_clr_pulses", 16'(clr_hits), 16'h0000);
    check("ss_clr_state", 16'(bus.oState), 16'h0001);

    // Reset in LAP with start/stop held through it.
    bus.iCount = 16'h0555;
    press(3'b100, 8, 10);
    tick();
    bus.iStartStop = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_lap_state", 16'(bus.oState), 16'h0000);
    check("rst_lap_en", 16'(bus.oCntEn), 16'h0000);
    check("rst_lap_disp", bus.oDisp, 16'h0555);
    repeat (6) @(negedge clk);
    check("held_edge6", 16'(bus.oState), 16'h0000);
    @(negedge clk);
    check("held_edge7", 16'(bus.oState), 16'h0001);
    repeat (10) @(negedge clk);
    check("held_once", 16'(bus.oState), 16'h0001);
    tick();
    bus.iStartStop = 1'b0;
    repeat (10) tick();

    // Randomized presses, counts and occasional resets.
    for (int k = 0; k < 160; k++) begin
      mask = 3'b001 << $urandom_range(0, 2);
      hold = $urandom_range(1, 10);
      gap  = $urandom_range(1, 12);
      set_btns(mask);
      for (int i = 0; i < hold; i++) tick_rand();
      set_btns(3'b000);
      for (int i = 0; i < gap; i++) tick_rand();
    end
    tick();
    rst = 1'b0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control block for the 4-digit BCD up-counter chain (units/tens/hundreds/thousands driven by the frequency-divider tick).
- Turns three raw push-buttons into a start/stop/clear/lap stopwatch: synchronises and debounces each button, runs a 4-state FSM, and gates the chain's count enable.
- Selects what the 7-segment decoders show: the live count, or a frozen lap snapshot.
- Sits between the board buttons and the counter/decoder datapath.

## Interface
- DEB_CYCLES, 16'd50000: consecutive stable cycles needed to accept a button level change (legal range 1..65535).
- iClk  in  1  system clock; all state changes on its rising edge.
- iRst  in  1  synchronous, active-high reset.
- iStartStop  in  1  raw start/stop button, active-high, asynchronous to iClk.
- iClear  in  1  raw clear button, active-high, asynchronous.
- iLap  in  1  raw lap button, active-high, asynchronous.
- iCount  in  16  live BCD count from the counter chain: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- oCntEn  out  1  count enable, ANDed with the divider tick at the units counter.
- oCntClr  out  1  one-cycle synchronous clear pulse to all four counters.
- oDisp  out  16  BCD value routed to the four decoders.
- oState  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

## Operation
- Each button has its own front end.
  - 2-flop synchroniser.
  - Debounce counter, clearing whenever the synchronised level equals the debounced level.
  - The debounced level flips when the counter reaches DEB_CYCLES-1 while the levels differ.
  - A rising edge of the debounced level produces a one-cycle event: evSS, evClr or evLap.
- FSM event priority within one cycle: evSS > evClr > evLap. Lower-priority events in the same cycle are dropped, not queued.
- IDLE
  - evSS → RUN.
  - evClr → stays in IDLE and pulses oCntClr.
  - evLap is ignored.
- RUN
  - evSS → PAUSE.
  - evLap → LAP; the lap register captures iCount in that same cycle.
  - evClr is ignored.
- PAUSE
  - evSS → RUN.
  - evClr → IDLE and pulses oCntClr.
  - evLap is ignored.
- LAP
  - evLap → RUN, releasing the frozen display.
  - evSS → PAUSE; the display returns to live.
  - evClr is ignored.
- oCntEn = 1 in RUN and LAP, 0 otherwise. The counter keeps running during LAP.
- oDisp = lap register in LAP, otherwise iCount.
- The lap register is 16 bits, written only on a RUN→LAP transition. It is never arithmetically modified, so BCD validity is the chain's responsibility.
- Wrap-around from 9999 to 0000 is handled by the chain. The controller does not react, and LAP stays frozen across the wrap.

## Timing
- Reset values:
  - FSM = IDLE.
  - oState = 00, oCntEn = 0, oCntClr = 0, oDisp = iCount.
  - Lap register = 16'h0000.
  - Debounced levels = 0; debounce counters = 0; synchroniser flops = 0.
- Button latency: a level stable from cycle t produces its event at t + 2 (sync) + DEB_CYCLES.
  - The FSM registers the transition on the following edge.
  - oState, oCntEn and oCntClr are registered outputs, valid one cycle after the event.
- oDisp is combinational from the state register, the lap register and iCount. It adds no extra cycle.
- oCntClr is high for exactly one cycle per accepted clear.
- Reset asserted mid-operation overrides everything on the next edge.
  - Pending debounce progress is discarded.
  - A button held through reset release must complete a full debounce from 0 and then produce an event. Its level is 1 against a debounced 0, so the release counts as a rising edge.
- Glitches shorter than DEB_CYCLES produce no event.

## Configuration
- STOPWATCH_LAP_EN defined: full behaviour above.
- STOPWATCH_LAP_EN undefined:
  - The iLap front end and the lap register are not synthesised; iLap is left unconnected internally.
  - State LAP is unreachable.
  - oDisp = iCount always; oState never shows 11.

## Test plan
Run with DEB_CYCLES = 4.
- Reset, then hold iStartStop 1 for 10 cycles → oState 00→01 on cycle 7 after press; oCntEn = 1 from then on.
- In RUN with iCount = 16'h0123, press iLap → oState = 11 and oDisp = 16'h0123. Then drive iCount 16'h0124..16'h0130 → oDisp holds 16'h0123 and oCntEn stays 1. Press iLap again → oState = 01 and oDisp follows iCount.
- RUN → press iStartStop (→ PAUSE, oCntEn = 0) → press iClear → oCntClr high exactly 1 cycle, oState = 00. iClear pressed in RUN → no oCntClr and oState stays 01.
- iStartStop toggling as 3-cycle pulses separated by 1-cycle gaps for 40 cycles → no event, oState unchanged.
- iStartStop and iClear debounced in the same cycle while in PAUSE → RUN, with no oCntClr.
- Assert iRst for 1 cycle while in LAP → next cycle oState = 00, oCntEn = 0, lap register = 0. A button held through reset fires once, 2 + DEB_CYCLES cycles after reset release.
